// File: rtl/amo_pkg.sv
// rtl/amo_pkg.sv - shared op/state encodings and decode helpers for the AMO sequencer.
package amo_pkg;
  `include "tags.svh"

  typedef enum logic [3:0] {
    OP_LW      = 4'd0,
    OP_SW      = 4'd1,
    OP_LR      = 4'd2,
    OP_SC      = 4'd3,
    OP_AMOSWAP = 4'd4,
    OP_AMOADD  = 4'd5,
    OP_AMOXOR  = 4'd6,
    OP_AMOAND  = 4'd7,
    OP_AMOOR   = 4'd8,
    OP_AMOMIN  = 4'd9,
    OP_AMOMAX  = 4'd10,
    OP_AMOMINU = 4'd11,
    OP_AMOMAXU = 4'd12
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_CALC,
    ST_WR,
    ST_DONE
  } state_e;

  function automatic logic op_defined(logic [3:0] op);
    return op <= OP_AMOMAXU;
  endfunction

  // LR/SC count as atomics: full-word select and word alignment apply to them too.
  function automatic logic op_atomic(logic [3:0] op);
    return (op >= OP_LR) && (op <= OP_AMOMAXU);
  endfunction

  function automatic logic op_amo(logic [3:0] op);
    return (op >= OP_AMOSWAP) && (op <= OP_AMOMAXU);
  endfunction

  function automatic logic op_writes_first(logic [3:0] op);
    return (op == OP_SW) || (op == OP_SC);
  endfunction

  function automatic logic [2:0] first_tag(logic [3:0] op);
    case (op)
      OP_LR:   return ADDR_TAG_LRSC_LOCK;
      OP_SC:   return ADDR_TAG_LRSC_UNLOCK;
      OP_LW,
      OP_SW:   return ADDR_TAG_NONE;
      default: return ADDR_TAG_AMO_LOCK;
    endcase
  endfunction
endpackage

// File: rtl/amo_alu.sv
// rtl/amo_alu.sv - combinational AMO read-modify-write function: result = f(op, old, operand).
module amo_alu
  import amo_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] old,
  input  logic [31:0] operand,
  output logic [31:0] result
);
  always_comb begin
    result = operand;
    case (op)
      OP_AMOSWAP: result = operand;
      OP_AMOADD:  result = old + operand;
      OP_AMOXOR:  result = old ^ operand;
      OP_AMOAND:  result = old & operand;
      OP_AMOOR:   result = old | operand;
      OP_AMOMIN:  result = ($signed(old) < $signed(operand)) ? old : operand;
      OP_AMOMAX:  result = ($signed(old) > $signed(operand)) ? old : operand;
      OP_AMOMINU: result = (old < operand) ? old : operand;
      OP_AMOMAXU: result = (old > operand) ? old : operand;
      default:    result = operand;
    endcase
  end
endmodule

// File: rtl/tags.svh
// rtl/tags.svh - io_bus address tag encodings {mode[1:0], lock}.
`ifndef AMO_TAGS_SVH
`define AMO_TAGS_SVH
localparam logic [1:0] ADDR_TAG_MODE_NONE = 2'b00;
localparam logic [1:0] ADDR_TAG_MODE_LRSC = 2'b01;
localparam logic [1:0] ADDR_TAG_MODE_AMO  = 2'b10;
localparam logic       ADDR_TAG_LOCK      = 1'b1;
localparam logic       ADDR_TAG_UNLOCK    = 1'b0;

localparam logic [2:0] ADDR_TAG_NONE        = {ADDR_TAG_MODE_NONE, ADDR_TAG_UNLOCK};
localparam logic [2:0] ADDR_TAG_LRSC_LOCK   = {ADDR_TAG_MODE_LRSC, ADDR_TAG_LOCK};
localparam logic [2:0] ADDR_TAG_LRSC_UNLOCK = {ADDR_TAG_MODE_LRSC, ADDR_TAG_UNLOCK};
localparam logic [2:0] ADDR_TAG_AMO_LOCK    = {ADDR_TAG_MODE_AMO, ADDR_TAG_LOCK};
localparam logic [2:0] ADDR_TAG_AMO_UNLOCK  = {ADDR_TAG_MODE_AMO, ADDR_TAG_UNLOCK};
`endif

// File: rtl/amo_sequencer.sv
// rtl/amo_sequencer.sv - sequences core loads/stores/LR/SC/AMOs into Wishbone read/write phases.
module amo_sequencer
  import amo_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_i,
  output logic        ready_o,
  input  logic [3:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [3:0]  sel_i,
  output logic        done_o,
  output logic [31:0] rdata_o,
  output logic        err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_addr_o,
  output logic [31:0] wb_data_o,
  output logic [3:0]  wb_sel_o,
  output logic [2:0]  wb_addr_tag_o,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  input  logic        wb_data_tag_i,
  input  logic [31:0] wb_data_i
);
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e            state_q, state_d;
  logic [3:0]        op_q;
  logic [31:0]       operand_q, old_q, alu_result;
  logic [CNT_W-1:0]  cnt_q;
  logic              req_bad, timeout, bus_ack, bus_err;

  amo_alu u_alu (
    .op      (op_q),
    .old     (old_q),
    .operand (operand_q),
    .result  (alu_result)
  );

  assign req_bad = !op_defined(op_i) || (op_atomic(op_i) && (addr_i[1:0] != 2'b00));
  // Responses only count while a strobe is out; err wins over a simultaneous ack.
  assign timeout = wb_stb_o && !wb_ack_i && !wb_err_i && (cnt_q == CNT_LAST);
  assign bus_err = (wb_stb_o && wb_err_i) || timeout;
  assign bus_ack = wb_stb_o && wb_ack_i && !wb_err_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready_o = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (req_i) begin
          if (req_bad)                   state_d = ST_DONE;
          else if (op_writes_first(op_i)) state_d = ST_WR;
          else                           state_d = ST_RD;
        end
      end
      ST_RD: begin
        if (bus_err)      state_d = ST_DONE;
        else if (bus_ack) state_d = op_amo(op_q) ? ST_CALC : ST_DONE;
      end
      ST_CALC: state_d = ST_WR;
      ST_WR: begin
        if (bus_err || bus_ack) state_d = ST_DONE;
      end
      ST_DONE: begin
        done_o  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      op_q          <= 4'd0;
      operand_q     <= 32'd0;
      old_q         <= 32'd0;
      cnt_q         <= '0;
      rdata_o       <= 32'd0;
      err_o         <= 1'b0;
      wb_cyc_o      <= 1'b0;
      wb_stb_o      <= 1'b0;
      wb_we_o       <= 1'b0;
      wb_addr_o     <= 32'd0;
      wb_data_o     <= 32'd0;
      wb_sel_o      <= 4'd0;
      wb_addr_tag_o <= ADDR_TAG_NONE;
    end else begin
      if (state_q == ST_IDLE || state_q == ST_CALC) cnt_q <= '0;
      else if (wb_stb_o)                            cnt_q <= cnt_q + CNT_W'(1);

      case (state_q)
        ST_IDLE: begin
          if (req_i) begin
            op_q      <= op_i;
            operand_q <= wdata_i;
            rdata_o   <= 32'd0;
            err_o     <= req_bad;
            if (!req_bad) begin
              wb_cyc_o      <= 1'b1;
              wb_stb_o      <= 1'b1;
              wb_we_o       <= op_writes_first(op_i);
              wb_addr_o     <= addr_i;
              wb_data_o     <= op_writes_first(op_i) ? wdata_i : 32'd0;
              wb_sel_o      <= op_atomic(op_i) ? 4'hF : sel_i;
              wb_addr_tag_o <= first_tag(op_i);
            end
          end
        end
        ST_RD: begin
          if (bus_err) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            err_o    <= 1'b1;
          end else if (bus_ack) begin
            wb_stb_o <= 1'b0;
            // AMOs keep the cycle (and the slave's lock) across CALC into the write.
            if (op_amo(op_q)) begin
              old_q <= wb_data_i;
            end else begin
              wb_cyc_o <= 1'b0;
              rdata_o  <= wb_data_i;
            end
          end
        end
        ST_CALC: begin
          wb_stb_o      <= 1'b1;
          wb_we_o       <= 1'b1;
          wb_data_o     <= alu_result;
          wb_addr_tag_o <= ADDR_TAG_AMO_UNLOCK;
        end
        ST_WR: begin
          if (bus_err) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            err_o    <= 1'b1;
          end else if (bus_ack) begin
            wb_stb_o <= 1'b0;
            wb_cyc_o <= 1'b0;
            if (op_q == OP_SW)      rdata_o <= 32'd0;
            else if (op_q == OP_SC) rdata_o <= {31'd0, wb_data_tag_i};
            else                    rdata_o <= old_q;
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/amo_sequencer.md
AMO_SEQUENCER -- requirements
Module: amo_sequencer

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: bus-phase cycles without ack/err before abort.
REQ-002 clk_i  in  1  single clock, all logic on rising edge.
REQ-003 rst_i  in  1  reset, synchronous and active-high.
REQ-004 req_i  in  1  core request valid; accepted when req_i & ready_o.
REQ-005 ready_o  out  1  high only in IDLE.
REQ-006 op_i  in  4  LW, SW, LR, SC, AMOSWAP, AMOADD, AMOXOR, AMOAND, AMOOR, AMOMIN, AMOMAX, AMOMINU, AMOMAXU.
REQ-007 addr_i / wdata_i  in  32 / 32  target address / store or AMO operand.
REQ-008 sel_i  in  4  byte enables, LW/SW only; atomics force 4'b1111.
REQ-009 done_o  out  1  one-cycle completion pulse; rdata_o (out, 32) and err_o (out, 1) valid with it.
REQ-010 wb_cyc_o, wb_stb_o, wb_we_o  out  1 each  Wishbone master controls toward io_bus.
REQ-011 wb_addr_o / wb_data_o / wb_sel_o / wb_addr_tag_o  out  32 / 32 / 4 / 3  address, write data, byte select, {mode[1:0], lock/unlock}.
REQ-012 wb_ack_i, wb_err_i, wb_data_tag_i  in  1 each; wb_data_i  in  32  slave response; data_tag = SC failed.

Function
REQ-013 States: IDLE, RD, CALC, WR, DONE; request captured (op, addr, wdata, sel) on acceptance.
REQ-014 IDLE -> RD for LW, LR, AMO*; IDLE -> WR for SW, SC; wb_cyc_o/wb_stb_o rise the cycle after acceptance.
REQ-015 Tags: LW/SW {NONE,x}; LR {LRSC,LOCK} we=0; SC {LRSC,UNLOCK} we=1; AMO read {AMO,LOCK} we=0; AMO write {AMO,UNLOCK} we=1; encodings from shared ADDR_TAG_* constants.
REQ-016 Address, tag, sel, data, we stay stable while wb_stb_o is high; stb held until ack or err.
REQ-017 On ack, wb_stb_o drops the next cycle and stays low at least one cycle before any new strobe.
REQ-018 RD ack: LW/LR -> DONE, rdata_o = wb_data_i; AMO -> CALC, old value latched, wb_cyc_o held high.
REQ-019 CALC lasts exactly one cycle: new = f(op, old, wdata); MIN/MAX signed 32-bit, MINU/MAXU unsigned, ADD wraps mod 2^32; then WR.
REQ-020 WR ack: SW -> rdata_o = 0; SC -> rdata_o = {31'b0, wb_data_tag_i} (0 success, 1 fail); AMO -> rdata_o = old value.
REQ-021 DONE: done_o = 1 for one cycle, wb_cyc_o = 0, then IDLE; ready_o low from acceptance through DONE.
REQ-022 Atomic op with addr[1:0] != 0, or undefined op: no bus cycle; DONE next cycle with err_o = 1, rdata_o = 0.
REQ-023 wb_err_i in any phase: stb/cyc drop next cycle, DONE with err_o = 1; AMO write phase skipped after read error.
REQ-024 Counter reset on each strobe start; reaching TIMEOUT_CYCLES without ack/err aborts as REQ-023.
REQ-025 wb_ack_i/wb_err_i while wb_stb_o low are ignored; ack and err together treated as err.
REQ-026 New req_i during a transaction is not accepted (ready_o = 0); core must hold it.

Reset
REQ-027 rst_i next edge: state IDLE, ready_o 1; done_o, err_o, wb_cyc_o, wb_stb_o, wb_we_o 0; rdata_o, wb_addr_o, wb_data_o 0; wb_sel_o 0; wb_addr_tag_o {NONE,0}; counter 0.
REQ-028 Reset mid-transaction abandons it without done_o; no write phase issued afterward.

Structure
REQ-029 Op enum, state enum and AMO function encoding live in shared package amo_pkg; ADDR_TAG_* stay in tags.svh.
REQ-030 Combinational sub-module amo_alu (op, old, operand -> new) holds REQ-019 arithmetic; sequencer instantiates it once.

Verification
REQ-031 AMOADD @0x0 old 0xFFFFFFFF, operand 2 -> read {AMO,LOCK}, one idle-stb cycle, write 0x00000001 {AMO,UNLOCK}, rdata_o 0xFFFFFFFF.
REQ-032 LR @0x10 then SC @0x10 wdata 0x55 -> SC rdata_o 0; LR @0x10, SW @0x10, SC @0x10 -> SC rdata_o 1, memory unchanged by SC.
REQ-033 AMOMIN old 0x80000000 operand 1 -> writes 0x80000000; AMOMINU same values -> writes 0x00000001.
REQ-034 AMOSWAP @0x2 -> no wb_stb_o, done_o next cycle with err_o 1; slave never acks, TIMEOUT_CYCLES 8 -> err_o after 8 cycles, cyc low.
REQ-035 rst_i asserted in CALC -> next cycle cyc/stb 0, ready_o 1, no done_o, no write phase on bus.
